// File: rtl/uart_host_ctrl.sv
// Host-side UART register bus initiator: programs the UART after reset,
// then polls LSR to move bytes between valid/ready streams and THR/RBR.
module uart_host_ctrl #(
   parameter logic [15:0] DIV     = 16'h0108,
   parameter logic [7:0]  LCR_CFG = 8'h03,
   parameter logic [7:0]  FCR_CFG = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   output logic       wr_o,
   output logic       rd_o,
   output logic [2:0] addr_o,
   output logic [7:0] din_o,
   input  logic [7:0] dout_i,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [3:0] rx_err,
   output logic       init_done
);

   localparam logic [3:0] INIT_LCRD = 4'd0;
   localparam logic [3:0] INIT_DLL  = 4'd1;
   localparam logic [3:0] INIT_DLM  = 4'd2;
   localparam logic [3:0] INIT_LCR  = 4'd3;
   localparam logic [3:0] INIT_FCR  = 4'd4;
   localparam logic [3:0] IDLE      = 4'd5;
   localparam logic [3:0] POLL_RD   = 4'd6;
   localparam logic [3:0] POLL_WAIT = 4'd7;
   localparam logic [3:0] RBR_RD    = 4'd8;
   localparam logic [3:0] RBR_WAIT  = 4'd9;
   localparam logic [3:0] THR_WR    = 4'd10;

   localparam logic [2:0] A_RBR = 3'd0;
   localparam logic [2:0] A_DLM = 3'd1;
   localparam logic [2:0] A_FCR = 3'd2;
   localparam logic [2:0] A_LCR = 3'd3;
   localparam logic [2:0] A_LSR = 3'd5;

   logic [3:0] state;
   logic [3:0] state_nx;
   logic [7:0] lsr_q;
   logic       unused_lsr;

   assign unused_lsr = ^{lsr_q[7:5], lsr_q[0]};

   // POLL_WAIT decides on the LSR value arriving this cycle (also latched)
   always_comb begin
      state_nx = state;
      case (state)
         INIT_LCRD: state_nx = INIT_DLL;
         INIT_DLL:  state_nx = INIT_DLM;
         INIT_DLM:  state_nx = INIT_LCR;
         INIT_LCR:  state_nx = INIT_FCR;
         INIT_FCR:  state_nx = IDLE;
         IDLE:      state_nx = POLL_RD;
         POLL_RD:   state_nx = POLL_WAIT;
         POLL_WAIT: begin
            if (dout_i[0] && !rx_valid)
               state_nx = RBR_RD;
            else if (tx_valid && dout_i[5])
               state_nx = THR_WR;
            else
               state_nx = IDLE;
         end
         RBR_RD:    state_nx = RBR_WAIT;
         RBR_WAIT:  state_nx = IDLE;
         THR_WR:    state_nx = IDLE;
         default:   state_nx = INIT_LCRD;
      endcase
   end

   // Bus strobes are quiet while reset is held, even though state is INIT_LCRD
   always_comb begin
      wr_o     = 1'b0;
      rd_o     = 1'b0;
      addr_o   = 3'd0;
      din_o    = 8'h00;
      tx_ready = 1'b0;
      if (!rst) begin
         unique case (1'b1)
            state == INIT_LCRD: begin
               wr_o   = 1'b1;
               addr_o = A_LCR;
               din_o  = 8'h80 | LCR_CFG;
            end
            state == INIT_DLL: begin
               wr_o   = 1'b1;
               addr_o = A_RBR;
               din_o  = DIV[7:0];
            end
            state == INIT_DLM: begin
               wr_o   = 1'b1;
               addr_o = A_DLM;
               din_o  = DIV[15:8];
            end
            state == INIT_LCR: begin
               wr_o   = 1'b1;
               addr_o = A_LCR;
               din_o  = LCR_CFG;
            end
            state == INIT_FCR: begin
               wr_o   = 1'b1;
               addr_o = A_FCR;
               din_o  = FCR_CFG;
            end
            state == POLL_RD: begin
               rd_o   = 1'b1;
               addr_o = A_LSR;
            end
            state == RBR_RD: begin
               rd_o   = 1'b1;
               addr_o = A_RBR;
            end
            state == THR_WR: begin
               wr_o     = 1'b1;
               addr_o   = A_RBR;
               din_o    = tx_data;
               tx_ready = 1'b1;
            end
            default: begin
               wr_o = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT_LCRD;
         lsr_q     <= 8'h00;
         rx_valid  <= 1'b0;
         rx_data   <= 8'h00;
         rx_err    <= 4'h0;
         init_done <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == POLL_WAIT)
            lsr_q <= dout_i;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         if (state == RBR_WAIT) begin
            rx_data  <= dout_i;
            rx_err   <= lsr_q[4:1];
            rx_valid <= 1'b1;
         end
         if (state == INIT_FCR)
            init_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl with a small UART register model.
module tb_uart_host_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_o;
   logic       rd_o;
   logic [2:0] addr_o;
   logic [7:0] din_o;
   logic [7:0] dout_i = 8'h00;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [3:0] rx_err;
   logic       init_done;

   logic [7:0]  lsr_m;
   logic [7:0]  rbr_m;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          tx_cnt = 0;
   logic [10:0] wr_q[$];
   logic [11:0] rx_q[$];
   int          wr_cyc[$];
   logic [10:0] mon_w;
   logic [11:0] mon_r;

   uart_host_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .wr_o      (wr_o),
      .rd_o      (rd_o),
      .addr_o    (addr_o),
      .din_o     (din_o),
      .dout_i    (dout_i),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_err    (rx_err),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   // UART register model: read data registered, valid the cycle after rd_o
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_o)
         dout_i <= (addr_o == 3'd5) ? lsr_m :
                   (addr_o == 3'd0) ? rbr_m : 8'h00;
   end

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t", n, act, exp, $time);
      end
   endtask

   task automatic fail_to(input string n);
      checks++;
      errors++;
      $display("FAIL %s: timeout @%0t", n, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_o) begin
            chk("wr_rd_excl", rd_o, 0);
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexp_wr: addr=%0d din=%02h none expected",
                        addr_o, din_o);
            end else begin
               mon_w = wr_q.pop_front();
               chk("wr", {addr_o, din_o}, mon_w);
            end
            if (addr_o == 3'd0)
               wr_cyc.push_back(cyc);
         end
         if (tx_ready) begin
            tx_cnt++;
            chk("tx_ready_wr", {wr_o, addr_o}, 4'b1000);
         end
         if (rd_o && addr_o == 3'd0)
            chk("rbr_rd_held", rx_valid, 0);
         if (rx_valid && rx_ready) begin
            if (rx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexp_rx: data=%02h err=%0h none expected",
                        rx_data, rx_err);
            end else begin
               mon_r = rx_q.pop_front();
               chk("rx", {rx_data, rx_err}, mon_r);
            end
         end
      end
   end

   task automatic chk_reset(input string n);
      chk(n, {wr_o, rd_o, addr_o, din_o, tx_ready, rx_valid,
              rx_data, rx_err, init_done}, 0);
   endtask

   task automatic do_init();
      wr_q.push_back({3'd3, 8'h83});
      wr_q.push_back({3'd0, 8'h08});
      wr_q.push_back({3'd1, 8'h01});
      wr_q.push_back({3'd3, 8'h03});
      wr_q.push_back({3'd2, 8'h01});
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("init_wr", wr_o, (i < 5) ? 1 : 0);
         chk("init_done", init_done, (i == 5) ? 1 : 0);
      end
      chk("init_q_empty", wr_q.size(), 0);
   endtask

   task automatic wait_rxv(input string n);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rx_valid) return;
      end
      fail_to(n);
   endtask

   task automatic send_byte(input logic [7:0] d);
      bit got = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      wr_q.push_back({3'd0, d});
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (tx_ready) got = 1;
      end
      if (!got) fail_to("tx_ready_wait");
      step();
      tx_valid = 1'b0;
   endtask

   initial begin
      int t0;
      bit hit;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rx_ready = 1'b0;
      lsr_m    = 8'h00;
      rbr_m    = 8'h00;
      repeat (3) step();
      @(negedge clk);
      chk_reset("reset_outs");
      do_init();

      // TX held off while THRE=0, then one write once THRE=1
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      repeat (30) step();
      chk("no_wr_thre0", tx_cnt, 0);
      lsr_m = 8'h60;
      send_byte(8'hA5);
      repeat (10) step();
      chk("tx_single_pulse", tx_cnt, 1);

      // RX byte held until accepted
      lsr_m = 8'h00;
      repeat (6) step();
      rbr_m = 8'h3C;
      rx_q.push_back({8'h3C, 4'h0});
      lsr_m = 8'h61;
      wait_rxv("rx_wait1");
      repeat (20) step();
      chk("rx_hold", {rx_valid, rx_data, rx_err}, {1'b1, 8'h3C, 4'h0});
      lsr_m    = 8'h00;
      rx_ready = 1'b1;
      @(negedge clk);
      step();
      rx_ready = 1'b0;
      @(negedge clk);
      chk("rx_clr", rx_valid, 0);

      // RX priority over TX, framing error reported with byte
      repeat (6) step();
      rbr_m = 8'h55;
      rx_q.push_back({8'h55, 4'b0100});
      tx_data  = 8'h7E;
      tx_valid = 1'b1;
      wr_q.push_back({3'd0, 8'h7E});
      lsr_m = 8'h69;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (rx_valid || tx_ready) hit = 1;
      end
      if (!hit) fail_to("prio_wait");
      chk("rx_first", {rx_valid, tx_ready}, 2'b10);
      hit = tx_ready;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (tx_ready) hit = 1;
      end
      if (!hit) fail_to("tx_after_rx");
      step();
      tx_valid = 1'b0;
      chk("rx_err_fe", rx_err, 4'b0100);
      lsr_m    = 8'h00;
      rx_ready = 1'b1;
      @(negedge clk);
      step();
      rx_ready = 1'b0;

      // Back-to-back TX stream
      repeat (6) step();
      lsr_m = 8'h60;
      wr_cyc.delete();
      t0 = tx_cnt;
      for (int k = 1; k <= 4; k++)
         send_byte(8'(k));
      lsr_m = 8'h00;
      chk("stream_cnt", tx_cnt - t0, 4);
      chk("stream_wrs", wr_cyc.size(), 4);
      for (int k = 1; k < 4; k++)
         if (k < wr_cyc.size())
            chk("stream_gap", wr_cyc[k] - wr_cyc[k-1], 4);

      // Reset with a byte pending
      rbr_m = 8'h99;
      lsr_m = 8'h61;
      wait_rxv("rx_wait2");
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk_reset("reset_rx_pending");
      lsr_m = 8'h00;
      do_init();
      repeat (10) step();
      chk("rx_none_after_rst", rx_valid, 0);

      // Reset landing in RBR_WAIT discards the byte
      rbr_m = 8'hC3;
      lsr_m = 8'h61;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (rd_o && addr_o == 3'd0) hit = 1;
      end
      if (!hit) fail_to("rbr_rd_wait");
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk_reset("reset_rbr_wait");
      lsr_m = 8'h00;
      do_init();
      repeat (10) step();
      chk("rx_discard", rx_valid, 0);
      chk("wr_q_drained", wr_q.size(), 0);
      chk("rx_q_drained", rx_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
